// File: rtl/dual_port_wait_mem.sv
// Dual-port word memory with a read-only fetch port and a byte-writable data port.
// Each port has its own wait-state counter, range check and error flag.
module dual_port_wait_mem #(
  parameter int unsigned           WORDS      = 1024,
  parameter int unsigned           WIDTH      = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           I_WAIT     = 0,
  parameter int unsigned           D_WAIT     = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0]      i_rdata,
  output logic                  i_err,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [WIDTH/8-1:0]    d_wen,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
  output logic [WIDTH-1:0]      d_rdata,
  output logic                  d_err
);

  localparam int unsigned NB   = WIDTH / 8;
  localparam int unsigned OFFS = $clog2(NB);
  localparam int unsigned IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0]  IWaitCnt = 4'(I_WAIT);
  localparam logic [3:0]  DWaitCnt = 4'(D_WAIT);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [WIDTH-1:0] mem_q [WORDS];

  state_e                i_state_q, i_state_d, d_state_q, d_state_d;
  logic [3:0]            i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
  logic [ADDR_WIDTH-1:0] i_addr_q, d_addr_q, i_acc_addr, d_acc_addr;
  logic [NB-1:0]         d_wen_q, d_acc_wen;
  logic [WIDTH-1:0]      d_wdata_q, d_acc_wdata;
  logic [WIDTH-1:0]      i_rdata_q, d_rdata_q;
  logic                  i_err_q, d_err_q;
  logic                  i_acc, d_acc;

  // In IDLE the access (zero wait) uses the live request; later it uses the latched copy.
  always_comb begin
    i_state_d  = i_state_q;
    i_cnt_d    = i_cnt_q;
    i_acc      = 1'b0;
    i_acc_addr = i_addr_q;
    unique case (i_state_q)
      StIdle: begin
        if (i_valid) begin
          i_acc_addr = i_addr;
          if (IWaitCnt == 4'd0) begin
            i_acc     = 1'b1;
            i_state_d = StResp;
          end else begin
            i_cnt_d   = IWaitCnt;
            i_state_d = StWait;
          end
        end
      end
      StWait: begin
        i_cnt_d = i_cnt_q - 4'd1;
        if (i_cnt_q == 4'd1) begin
          i_acc     = 1'b1;
          i_state_d = StResp;
        end
      end
      StResp:  i_state_d = StIdle;
      default: i_state_d = StIdle;
    endcase
  end

  always_comb begin
    d_state_d   = d_state_q;
    d_cnt_d     = d_cnt_q;
    d_acc       = 1'b0;
    d_acc_addr  = d_addr_q;
    d_acc_wen   = d_wen_q;
    d_acc_wdata = d_wdata_q;
    unique case (d_state_q)
      StIdle: begin
        if (d_valid) begin
          d_acc_addr  = d_addr;
          d_acc_wen   = d_wen;
          d_acc_wdata = d_wdata;
          if (DWaitCnt == 4'd0) begin
            d_acc     = 1'b1;
            d_state_d = StResp;
          end else begin
            d_cnt_d   = DWaitCnt;
            d_state_d = StWait;
          end
        end
      end
      StWait: begin
        d_cnt_d = d_cnt_q - 4'd1;
        if (d_cnt_q == 4'd1) begin
          d_acc     = 1'b1;
          d_state_d = StResp;
        end
      end
      StResp:  d_state_d = StIdle;
      default: d_state_d = StIdle;
    endcase
  end

  // Borrow out of the subtraction flags addresses below BASE_ADDR.
  logic [ADDR_WIDTH:0]   i_off, d_off;
  logic [ADDR_WIDTH-1:0] i_word, d_word;
  logic                  i_hit, d_hit;

  assign i_off  = {1'b0, i_acc_addr} - {1'b0, BASE_ADDR};
  assign d_off  = {1'b0, d_acc_addr} - {1'b0, BASE_ADDR};
  assign i_word = i_off[ADDR_WIDTH-1:0] >> OFFS;
  assign d_word = d_off[ADDR_WIDTH-1:0] >> OFFS;
  assign i_hit  = !i_off[ADDR_WIDTH] && (i_word < ADDR_WIDTH'(WORDS));
  assign d_hit  = !d_off[ADDR_WIDTH] && (d_word < ADDR_WIDTH'(WORDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      i_state_q <= StIdle;
      d_state_q <= StIdle;
      i_cnt_q   <= '0;
      d_cnt_q   <= '0;
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_wen_q   <= '0;
      d_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      i_state_q <= i_state_d;
      d_state_q <= d_state_d;
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
      if (i_state_q == StIdle && i_valid) begin
        i_addr_q <= i_addr;
      end
      if (d_state_q == StIdle && d_valid) begin
        d_addr_q  <= d_addr;
        d_wen_q   <= d_wen;
        d_wdata_q <= d_wdata;
      end
      if (i_acc) begin
        i_rdata_q <= i_hit ? mem_q[i_word[IW-1:0]] : '0;
        i_err_q   <= !i_hit;
      end
      if (d_acc) begin
        d_rdata_q <= d_hit ? mem_q[d_word[IW-1:0]] : '0;
        d_err_q   <= !d_hit;
      end
    end
  end

  // Nonblocking write gives read-before-write for both ports on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && d_acc && d_hit) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (d_acc_wen[b]) begin
          mem_q[d_word[IW-1:0]][b*8 +: 8] <= d_acc_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign i_ready = (i_state_q == StResp);
  assign d_ready = (d_state_q == StResp);
  assign i_rdata = i_rdata_q;
  assign i_err   = i_err_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;

endmodule

// File: tb/tb_dual_port_wait_mem.sv
// Directed bench: dut_a has zero wait states on both ports, dut_b has I_WAIT=3, D_WAIT=2.
module tb_dual_port_wait_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        a_i_valid, a_i_ready, a_i_err, a_d_valid, a_d_ready, a_d_err;
  logic        b_i_valid, b_i_ready, b_i_err, b_d_valid, b_d_ready, b_d_err;
  logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [3:0]  a_d_wen, b_d_wen;

  int n_checks = 0;
  int n_errors = 0;

  dual_port_wait_mem #(
    .WORDS(256), .WIDTH(32), .ADDR_WIDTH(32), .I_WAIT(0), .D_WAIT(0), .BASE_ADDR(32'h0)
  ) dut_a (
    .clk(clk), .rst(rst_a),
    .i_valid(a_i_valid), .i_ready(a_i_ready), .i_addr(a_i_addr), .i_rdata(a_i_rdata),
    .i_err(a_i_err),
    .d_valid(a_d_valid), .d_ready(a_d_ready), .d_wen(a_d_wen), .d_addr(a_d_addr),
    .d_wdata(a_d_wdata), .d_rdata(a_d_rdata), .d_err(a_d_err)
  );

  dual_port_wait_mem #(
    .WORDS(256), .WIDTH(32), .ADDR_WIDTH(32), .I_WAIT(3), .D_WAIT(2), .BASE_ADDR(32'h0)
  ) dut_b (
    .clk(clk), .rst(rst_b),
    .i_valid(b_i_valid), .i_ready(b_i_ready), .i_addr(b_i_addr), .i_rdata(b_i_rdata),
    .i_err(b_i_err),
    .d_valid(b_d_valid), .d_ready(b_d_ready), .d_wen(b_d_wen), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_rdata(b_d_rdata), .d_err(b_d_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Port ids: 0 = dut_a D, 1 = dut_a I, 2 = dut_b I, 3 = dut_b D.
  task automatic drive(input int p, input logic v, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    case (p)
      0: begin a_d_valid = v; a_d_wen = wen; a_d_addr = addr; a_d_wdata = wdata; end
      1: begin a_i_valid = v; a_i_addr = addr; end
      2: begin b_i_valid = v; b_i_addr = addr; end
      default: begin b_d_valid = v; b_d_wen = wen; b_d_addr = addr; b_d_wdata = wdata; end
    endcase
  endtask

  function automatic logic rdy(input int p);
    case (p)
      0: return a_d_ready;
      1: return a_i_ready;
      2: return b_i_ready;
      default: return b_d_ready;
    endcase
  endfunction

  function automatic logic [31:0] rdat(input int p);
    case (p)
      0: return a_d_rdata;
      1: return a_i_rdata;
      2: return b_i_rdata;
      default: return b_d_rdata;
    endcase
  endfunction

  function automatic logic erf(input int p);
    case (p)
      0: return a_d_err;
      1: return a_i_err;
      2: return b_i_err;
      default: return b_d_err;
    endcase
  endfunction

  function automatic int lat_of(input int p);
    case (p)
      2: return 4;
      3: return 3;
      default: return 1;
    endcase
  endfunction

  // One complete transaction with latency and single-cycle ready checks.
  task automatic xact(input int p, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    drive(p, 1'b1, wen, addr, wdata);
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rdy(p) && n < 40);
    check($sformatf("latency p%0d @%08h", p, addr), 32'(n), 32'(lat_of(p)));
    rd = rdat(p);
    er = erf(p);
    drive(p, 1'b0, wen, addr, wdata);
    @(posedge clk);
    #1;
    check($sformatf("ready pulse width p%0d", p), 32'(rdy(p)), 32'd0);
  endtask

  typedef struct {
    int          p;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int p, input logic [3:0] wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic chk_rd, input logic [31:0] exp_rd,
                     input logic exp_err);
    vec_t v;
    v.p = p; v.wen = wen; v.addr = addr; v.wdata = wdata;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(2, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      check($sformatf("reset ready p%0d", p), 32'(rdy(p)), 32'd0);
      check($sformatf("reset rdata p%0d", p), rdat(p), 32'd0);
      check($sformatf("reset err p%0d", p), 32'(erf(p)), 32'd0);
    end
    rst_a = 1'b0; rst_b = 1'b0;

    add(0, 4'hF, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0);
    add(0, 4'h0, 32'h10,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0);
    add(1, 4'h0, 32'h10,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0);
    add(0, 4'hF, 32'h20,  32'h11223344, 1'b0, 32'h0,        1'b0);
    add(0, 4'h5, 32'h20,  32'hAABBCCDD, 1'b1, 32'h11223344, 1'b0);
    add(0, 4'h0, 32'h20,  32'h0,        1'b1, 32'h11BB33DD, 1'b0);
    add(0, 4'h0, 32'h23,  32'h0,        1'b1, 32'h11BB33DD, 1'b0);
    add(0, 4'hF, 32'h0,   32'h00000077, 1'b0, 32'h0,        1'b0);
    add(0, 4'h0, 32'h400, 32'h0,        1'b1, 32'h0,        1'b1);
    add(0, 4'hF, 32'h400, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1);
    add(0, 4'h0, 32'h0,   32'h0,        1'b1, 32'h00000077, 1'b0);
    add(1, 4'h0, 32'h400, 32'h0,        1'b1, 32'h0,        1'b1);
    add(0, 4'hF, 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0);
    add(1, 4'h0, 32'h3FC, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0);
    add(0, 4'h8, 32'h10,  32'h99000000, 1'b1, 32'hDEADBEEF, 1'b0);
    add(0, 4'h0, 32'h10,  32'h0,        1'b1, 32'h99ADBEEF, 1'b0);

    foreach (vecs[i]) begin
      xact(vecs[i].p, vecs[i].wen, vecs[i].addr, vecs[i].wdata, rd, er);
      if (vecs[i].chk_rd) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Same-edge D write and I read of word 3.
    xact(0, 4'hF, 32'hC, 32'h00001234, rd, er);
    drive(0, 1'b1, 4'hF, 32'hC, 32'h5);
    drive(1, 1'b1, 4'h0, 32'hC, 32'h0);
    @(posedge clk);
    #1;
    check("same-edge i_ready", 32'(a_i_ready), 32'd1);
    check("same-edge d_ready", 32'(a_d_ready), 32'd1);
    check("same-edge i_rdata old", a_i_rdata, 32'h00001234);
    check("same-edge d_rdata old", a_d_rdata, 32'h00001234);
    drive(0, 1'b0, 4'h0, 32'hC, 32'h0);
    drive(1, 1'b0, 4'h0, 32'hC, 32'h0);
    @(posedge clk);
    #1;
    xact(1, 4'h0, 32'hC, 32'h0, rd, er);
    check("same-edge next i read", rd, 32'h5);

    // Valid held high on a zero-wait port: ready every second cycle.
    drive(0, 1'b1, 4'h0, 32'h10, 32'h0);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("back-to-back ready edge %0d", e), 32'(a_d_ready), 32'(e % 2));
    end
    drive(0, 1'b0, 4'h0, 32'h10, 32'h0);
    check("back-to-back rdata", a_d_rdata, 32'h99ADBEEF);

    // dut_b contents, then I_WAIT=3 cycle-exact with address changed mid-WAIT.
    xact(3, 4'hF, 32'h40, 32'hA5A5A5A5, rd, er);
    xact(3, 4'hF, 32'h44, 32'h5A5A5A5A, rd, er);
    drive(2, 1'b1, 4'h0, 32'h40, 32'h0);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("i_wait3 ready edge %0d", e), 32'(b_i_ready), 32'(e == 4));
      if (e == 1) b_i_addr = 32'h44;
    end
    check("i_wait3 rdata uses latched addr", b_i_rdata, 32'hA5A5A5A5);
    drive(2, 1'b0, 4'h0, 32'h44, 32'h0);
    @(posedge clk);
    #1;
    check("i_wait3 ready drops", 32'(b_i_ready), 32'd0);

    // Reset mid-WAIT (k=1) and on the access edge (k=2): no write, no ready.
    for (int k = 1; k <= 2; k++) begin
      drive(3, 1'b1, 4'hF, 32'h40, 32'hFFFF0000 + 32'(k));
      for (int e = 0; e < k; e++) begin
        @(posedge clk);
        #1;
        check($sformatf("rst k%0d pre ready", k), 32'(b_d_ready), 32'd0);
      end
      rst_b = 1'b1;
      drive(3, 1'b0, 4'h0, 32'h40, 32'h0);
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      check($sformatf("rst k%0d d_rdata", k), b_d_rdata, 32'h0);
      check($sformatf("rst k%0d d_err", k), 32'(b_d_err), 32'd0);
      check($sformatf("rst k%0d i_rdata", k), b_i_rdata, 32'h0);
      check($sformatf("rst k%0d i_ready", k), 32'(b_i_ready), 32'd0);
      for (int e = 0; e < 4; e++) begin
        @(posedge clk);
        #1;
        check($sformatf("rst k%0d no ready", k), 32'(b_d_ready), 32'd0);
      end
      xact(3, 4'h0, 32'h40, 32'h0, rd, er);
      check($sformatf("rst k%0d word unchanged", k), rd, 32'hA5A5A5A5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dual_port_wait_mem.md
Name: dual_port_wait_mem

Overview:
Parametrised successor of the single-port simulation memory. It provides two independent valid/ready ports:
- I-port: read-only instruction fetch.
- D-port: read/write data with byte enables.

Both ports share one word array. Each port has its own programmable wait-state count, range checking and an error flag. The block sits between the core's fetch/LSU bus masters and backing storage, for simulation and FPGA block RAM.

Parameters:
WORDS, 1024, number of WIDTH-bit words in the array
WIDTH, 32, word/data width in bits (32 or 64, matches XLEN)
ADDR_WIDTH, 32, byte-address width of both ports
I_WAIT, 0, extra wait cycles per I-port access (0..15)
D_WAIT, 0, extra wait cycles per D-port access (0..15)
BASE_ADDR, 0, byte address mapped to word 0

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
i_valid  in  1  I-port request
i_ready  out  1  I-port completion pulse
i_addr  in  ADDR_WIDTH  I-port byte address
i_rdata  out  WIDTH  I-port read data
i_err  out  1  I-port out-of-range, valid with i_ready
d_valid  in  1  D-port request
d_ready  out  1  D-port completion pulse
d_wen  in  WIDTH/8  D-port byte write enables; 0 = read
d_addr  in  ADDR_WIDTH  D-port byte address
d_wdata  in  WIDTH  D-port write data
d_rdata  out  WIDTH  D-port read data (read-before-write)
d_err  out  1  D-port out-of-range, valid with d_ready

Behaviour:
- Word index: (addr - BASE_ADDR) >> log2(WIDTH/8).
  - Low byte-offset bits are ignored; accesses are word-aligned.
  - Out of range when addr < BASE_ADDR or index >= WORDS.
- Reset: i_ready=d_ready=0, i_rdata=d_rdata=0, i_err=d_err=0, both FSMs go to IDLE. Array contents are not cleared.
- Per-port FSM, identical for I and D, with states IDLE, WAIT, RESP:
  - IDLE: on valid=1, latch addr, wen and wdata.
    - Wait count 0: perform the access at this edge and go to RESP.
    - Otherwise: load counter = wait count and go to WAIT.
  - WAIT: decrement the counter each cycle. At counter==1, perform the access at that edge and go to RESP.
  - RESP: ready=1 for exactly one cycle, then return to IDLE.
- Latency: valid sampled at edge N gives ready high during cycle N+1+wait. Maximum rate is one access per 2+wait cycles.
- Requester rules:
  - Hold valid, addr, wen and wdata stable until ready is seen.
  - Lower valid in the ready cycle, or keep it high to start the next access immediately after RESP.
  - The block uses only the latched request values. Changes on the inputs during WAIT are ignored.
- Access, performed at one edge:
  - rdata <= array word.
  - For each byte b with wen[b]=1, write byte b of wdata.
  - Out-of-range: rdata <= 0, err <= 1, no write. Otherwise err <= 0.
- rdata/err hold their values until the next access completes.
- I-port never writes. It has no wen input.
- Same word, same edge:
  - I-port read and D-port write: i_rdata returns the OLD word; the new word is visible from the next access.
  - D-port read-before-write: d_rdata of a write returns the pre-write word.
- The ports are fully independent. No arbitration and no mutual stall.
- Reset mid-WAIT: the transaction is aborted. No write occurs and no ready is issued.
- Reset on the same edge an access would be performed: the reset wins and no write occurs.

Test Plan:
- D_WAIT=0: write 0xDEADBEEF to 0x10 with wen=4'hF, then read 0x10 -> d_ready pulses exactly 1 cycle after each valid edge; d_rdata=0xDEADBEEF, d_err=0.
- Byte enables: word 0x20 = 0x11223344, write 0xAABBCCDD with wen=4'b0101, then read -> 0x11BB33DD. The write's own d_rdata = 0x11223344.
- I_WAIT=3: i_valid at edge N -> i_ready high only in cycle N+4. Changing i_addr during WAIT does not alter i_rdata.
- Same edge: D-port writes 0x5 to word 3 while I-port reads word 3 (both WAIT=0) -> i_rdata = old value. The next I read returns 0x5.
- WORDS=256, WIDTH=32, BASE_ADDR=0: read 0x400 and write 0x400 -> d_err=1, d_rdata=0. A follow-up read at 0x0 is unchanged and gives err=0.
- D_WAIT=2: write issued, rst pulsed during WAIT -> no d_ready, target word unchanged, all outputs 0. valid held high continuously with WAIT=0 -> d_ready every 2nd cycle.
